fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO: dual-port storage plus pointer/occupancy control in one block, replacing externally driven read/write addresses.
Sits between a producer and a consumer on one clock domain, with push/pop handshakes and status flags.

---
 rtl/fifo_sync_param_pkg.sv | 11 +
 rtl/fifo_sync_param_if.sv | 34 +++
 rtl/fifo_mem_dp.sv | 36 +++
 rtl/fifo_sync_param.sv | 84 ++++++++
 tb/tb_fifo_sync_param.sv | 138 +++++++++++++
 5 files changed

// File: rtl/fifo_sync_param_pkg.sv
// rtl/fifo_sync_param_pkg.sv - shared defaults and depth helper for the synchronous FIFO
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 10;
   localparam int FIFO_ADDR_WIDTH = 3;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer handshake and status bundle of the FIFO
interface fifo_sync_param_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
   logic [DATA_WIDTH-1:0] Fifo_Data_in;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH:0]   almost_full_th;
   logic [ADDR_WIDTH:0]   almost_empty_th;
   logic [DATA_WIDTH-1:0] Fifo_Data_out;
   logic                  data_valid;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  overflow_err;
   logic                  underflow_err;

   modport master (
      output Fifo_Data_in, push, pop, almost_full_th, almost_empty_th,
      input  Fifo_Data_out, data_valid, count, full, empty,
             almost_full, almost_empty, overflow_err, underflow_err
   );

   modport slave (
      input  Fifo_Data_in, push, pop, almost_full_th, almost_empty_th,
      output Fifo_Data_out, data_valid, count, full, empty,
             almost_full, almost_empty, overflow_err, underflow_err
   );
endinterface

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - dual-port RAM with one write port and one registered read port
module fifo_mem_dp
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is never cleared; only the output register is reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Same-address read and write return the old word (read-before-write).
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end
endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - synchronous FIFO: pointers, occupancy, flags and sticky errors
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          reset_L,
   fifo_sync_param_if.slave bus
);
   localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic                  data_valid_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  full;
   logic                  empty;
   logic                  pop_ok;
   logic                  push_ok;

   assign full    = (count_q == DEPTH_CNT);
   assign empty   = (count_q == '0);
   assign pop_ok  = bus.pop & ~empty;
   assign push_ok = bus.push & (~full | pop_ok);

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         data_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         if (push_ok && !pop_ok) begin
            count_q <= count_q + (ADDR_WIDTH+1)'(1);
         end else if (pop_ok && !push_ok) begin
            count_q <= count_q - (ADDR_WIDTH+1)'(1);
         end
         data_valid_q <= pop_ok;
         if (bus.push && !push_ok) begin
            overflow_q <= 1'b1;
         end
         if (bus.pop && empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   // Gating with reset_L keeps a push/pop coincident with reset from touching the RAM.
   fifo_mem_dp #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .reset_L (reset_L),
      .wr_en   (push_ok & reset_L),
      .wr_addr (wr_ptr),
      .wr_data (bus.Fifo_Data_in),
      .rd_en   (pop_ok & reset_L),
      .rd_addr (rd_ptr),
      .rd_data (bus.Fifo_Data_out)
   );

   assign bus.data_valid    = data_valid_q;
   assign bus.count         = count_q;
   assign bus.full          = full;
   assign bus.empty         = empty;
   assign bus.almost_full   = (count_q >= bus.almost_full_th);
   assign bus.almost_empty  = (count_q <= bus.almost_empty_th);
   assign bus.overflow_err  = overflow_q;
   assign bus.underflow_err = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed table-driven bench for the synchronous FIFO
module tb_fifo_sync_param;
   localparam int DW = 10;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic reset_L = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   typedef struct {
      bit          rst;
      bit          push;
      bit          pop;
      logic [9:0]  din;
      logic [3:0]  cnt;
      bit          dv;
      logic [9:0]  dout;
      bit          ovf;
      bit          udf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, bit push, bit pop, logic [9:0] din,
                               logic [3:0] cnt, bit dv, logic [9:0] dout, bit ovf, bit udf);
      vec_t v;
      v.rst = rst; v.push = push; v.pop = pop; v.din = din;
      v.cnt = cnt; v.dv = dv; v.dout = dout; v.ovf = ovf; v.udf = udf;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit push, input bit pop, input logic [9:0] din);
      @(negedge clk);
      reset_L          = !rst;
      bus.push         = push;
      bus.pop          = pop;
      bus.Fifo_Data_in = din;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [3:0] cnt, input bit dv,
                              input logic [9:0] dout, input bit ovf, input bit udf);
      check({tag, ".count"}, 32'(bus.count), 32'(cnt));
      check({tag, ".data_valid"}, 32'(bus.data_valid), 32'(dv));
      check({tag, ".dout"}, 32'(bus.Fifo_Data_out), 32'(dout));
      check({tag, ".overflow"}, 32'(bus.overflow_err), 32'(ovf));
      check({tag, ".underflow"}, 32'(bus.underflow_err), 32'(udf));
      check({tag, ".full"}, 32'(bus.full), 32'(cnt == 4'd8));
      check({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 4'd0));
      check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(cnt >= bus.almost_full_th));
      check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= bus.almost_empty_th));
   endtask

   initial begin
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.Fifo_Data_in = '0;
      bus.almost_full_th = 4'd6;
      bus.almost_empty_th = 4'd2;

      // reset, idle, fill, overflow attempt, drain
      add(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0);
      for (int i = 1; i <= 8; i++) add(0, 1, 0, 10'(i), 4'(i), 0, 10'h000, 0, 0);
      add(0, 1, 0, 10'h3FF, 8, 0, 10'h000, 1, 0);
      for (int i = 1; i <= 8; i++) add(0, 0, 1, 10'h000, 4'(8 - i), 1, 10'(i), 1, 0);
      add(0, 0, 0, 10'h000, 0, 0, 10'h008, 1, 0);
      // full with simultaneous push/pop, then empty with simultaneous push/pop
      add(1, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0);
      for (int i = 1; i <= 8; i++) add(0, 1, 0, 10'(i + 16), 4'(i), 0, 10'h000, 0, 0);
      add(0, 1, 1, 10'h155, 8, 1, 10'h011, 0, 0);
      for (int i = 2; i <= 8; i++) add(0, 0, 1, 10'h000, 4'(9 - i), 1, 10'(i + 16), 0, 0);
      add(0, 0, 1, 10'h000, 0, 1, 10'h155, 0, 0);
      add(0, 1, 1, 10'h0AA, 1, 0, 10'h155, 0, 1);
      add(0, 0, 1, 10'h000, 0, 1, 10'h0AA, 0, 1);
      add(0, 0, 1, 10'h000, 0, 0, 10'h0AA, 0, 1);

      foreach (vecs[k]) begin
         step(vecs[k].rst, vecs[k].push, vecs[k].pop, vecs[k].din);
         check_state($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].dv,
                     vecs[k].dout, vecs[k].ovf, vecs[k].udf);
      end

      // threshold crossings while filling
      step(1, 0, 0, 10'h000);
      for (int i = 1; i <= 6; i++) begin
         step(0, 1, 0, 10'(10'h200 + i));
         check($sformatf("thr%0d.almost_empty", i), 32'(bus.almost_empty), 32'(i <= 2));
         check($sformatf("thr%0d.almost_full", i), 32'(bus.almost_full), 32'(i >= 6));
      end

      // reset mid-stream dominates a simultaneous push/pop
      step(1, 1, 1, 10'h3C3);
      check_state("midrst", 0, 0, 10'h000, 0, 0);

      // threshold extremes with an empty FIFO, applied live
      bus.almost_full_th = 4'd0;
      bus.almost_empty_th = 4'd8;
      #1;
      check("af_th0", 32'(bus.almost_full), 32'd1);
      check("ae_th8", 32'(bus.almost_empty), 32'd1);
      bus.almost_full_th = 4'd8;
      bus.almost_empty_th = 4'd0;
      #1;
      check("af_th8", 32'(bus.almost_full), 32'd0);
      check("ae_th0", 32'(bus.almost_empty), 32'd1);

      // contents were discarded: the next pop returns only the fresh word
      step(0, 1, 0, 10'h2A5);
      step(0, 0, 1, 10'h000);
      check("post_rst.dout", 32'(bus.Fifo_Data_out), 32'h2A5);
      check("post_rst.dv", 32'(bus.data_valid), 32'd1);
      check("post_rst.empty", 32'(bus.empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
